// File: rtl/micro_sequencer.sv
// Program loader and run control for the 16-bit core: bytes to IRAM words,
// then free-run or single-step PC enable with jump-to-self halt detection.
module micro_sequencer #(
    parameter int WIDTH          = 16,
    parameter int IRAM_ADDR_BITS = 8,
    parameter int RUN_DIV        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_start,
    input  logic                          run_start,
    input  logic                          step_req,
    input  logic                          stop_req,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic [2*IRAM_ADDR_BITS-1:0]   mon_pc,
    output logic [IRAM_ADDR_BITS-1:0]     iram_wa,
    output logic                          iram_wen,
    output logic [WIDTH-1:0]              iram_din,
    output logic                          pc_enable,
    output logic                          cpu_reset,
    output logic [1:0]                    state,
    output logic [IRAM_ADDR_BITS:0]       load_count,
    output logic                          halted
);

    localparam int AW = IRAM_ADDR_BITS;
    localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            pc_enable_q, pc_enable_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [AW:0]     lc_q, lc_d;
    logic            halted_q, halted_d;
    logic            phase_hi_q, phase_hi_d;
    logic [7:0]      hi_q, hi_d;
    logic [DW-1:0]   div_q, div_d;

    logic pc_match;
    logic tick;
    logic go_load;

    assign pc_match = (mon_pc[2*AW-1:AW] == mon_pc[AW-1:0]);
    assign tick     = (div_q == DW'(RUN_DIV - 1));

    always_comb begin
        state_d     = state_q;
        cpu_reset_d = cpu_reset_q;
        pc_enable_d = 1'b0;
        wen_d       = 1'b0;
        wa_d        = wa_q;
        din_d       = din_q;
        lc_d        = lc_q;
        halted_d    = halted_q;
        phase_hi_d  = phase_hi_q;
        hi_d        = hi_q;
        div_d       = div_q;
        go_load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (load_start) begin
                    go_load = 1'b1;
                end else if (run_start) begin
                    state_d     = S_RUN;
                    div_d       = '0;
                    cpu_reset_d = 1'b0;
                end else if (step_req) begin
                    cpu_reset_d = 1'b0;
                    if (pc_match) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_enable_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // address follows the count once the write cycle is over
                if (wen_q && !lc_q[AW]) begin
                    wa_d = lc_q[AW-1:0];
                end
                if (stop_req || load_start || lc_q[AW]) begin
                    state_d    = S_IDLE;
                    phase_hi_d = 1'b1;
                end else if (rx_valid) begin
                    if (phase_hi_q) begin
                        hi_d       = rx_data;
                        phase_hi_d = 1'b0;
                    end else begin
                        din_d      = WIDTH'({hi_q, rx_data});
                        wen_d      = 1'b1;
                        lc_d       = lc_q + 1'b1;
                        phase_hi_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (load_start) begin
                    go_load = 1'b1;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        if (pc_match) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_enable_d = 1'b1;
                        end
                    end
                end
            end
            S_HALT: begin
                if (stop_req) begin
                    state_d  = S_IDLE;
                    halted_d = 1'b0;
                end else if (load_start) begin
                    go_load  = 1'b1;
                    halted_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_load) begin
            state_d     = S_LOAD;
            lc_d        = '0;
            wa_d        = '0;
            phase_hi_d  = 1'b1;
            cpu_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cpu_reset_q <= 1'b1;
            pc_enable_q <= 1'b0;
            wen_q       <= 1'b0;
            wa_q        <= '0;
            din_q       <= '0;
            lc_q        <= '0;
            halted_q    <= 1'b0;
            phase_hi_q  <= 1'b1;
            hi_q        <= '0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            pc_enable_q <= pc_enable_d;
            wen_q       <= wen_d;
            wa_q        <= wa_d;
            din_q       <= din_d;
            lc_q        <= lc_d;
            halted_q    <= halted_d;
            phase_hi_q  <= phase_hi_d;
            hi_q        <= hi_d;
            div_q       <= div_d;
        end
    end

    assign state      = state_q;
    assign cpu_reset  = cpu_reset_q;
    assign pc_enable  = pc_enable_q;
    assign iram_wen   = wen_q;
    assign iram_wa    = wa_q;
    assign iram_din   = din_q;
    assign load_count = lc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: RAM writes checked through a
// scoreboard queue, run/step/halt/reset checked inline.
module tb_micro_sequencer;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        run_start;
    logic        step_req;
    logic        stop_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] mon_pc;
    logic [7:0]  iram_wa;
    logic        iram_wen;
    logic [15:0] iram_din;
    logic        pc_enable;
    logic        cpu_reset;
    logic [1:0]  state;
    logic [8:0]  load_count;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;
    logic [23:0] sb[$];

    micro_sequencer #(
        .WIDTH(16),
        .IRAM_ADDR_BITS(8),
        .RUN_DIV(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_start(load_start),
        .run_start(run_start),
        .step_req(step_req),
        .stop_req(stop_req),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .mon_pc(mon_pc),
        .iram_wa(iram_wa),
        .iram_wen(iram_wen),
        .iram_din(iram_din),
        .pc_enable(pc_enable),
        .cpu_reset(cpu_reset),
        .state(state),
        .load_count(load_count),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // write monitor: every write must match the oldest expected entry
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (iram_wen === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {8'h0, iram_wa, iram_din}, 32'hFFFF_FFFF);
                end else begin
                    chk("iram_write", {8'h0, iram_wa, iram_din}, {8'h0, sb.pop_front()});
                end
            end
            if (state === 2'd1) begin
                chk("cpu_reset_in_load", cpu_reset, 1);
            end
        end
    end

    initial begin
        reset = 1'b0;
        load_start = 0; run_start = 0; step_req = 0; stop_req = 0;
        rx_data = 8'h00; rx_valid = 0;
        mon_pc = 16'h0304;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_pc_enable", pc_enable, 0);
        chk("rst_wen", iram_wen, 0);
        chk("rst_wa", iram_wa, 0);
        chk("rst_din", iram_din, 0);
        chk("rst_count", load_count, 0);
        chk("rst_halted", halted, 0);
        reset = 1'b1;
        tick();

        // basic two-word load
        pulse_load();
        chk("load_state", state, 1);
        chk("load_cpu_reset", cpu_reset, 1);
        send_byte(8'h12);
        sb.push_back({8'd0, 16'h1234});
        send_byte(8'h34);
        send_byte(8'hAB);
        sb.push_back({8'd1, 16'hABCD});
        send_byte(8'hCD);
        pulse_load();
        chk("load_exit_state", state, 0);
        chk("load_count2", load_count, 2);
        chk("load_wa2", iram_wa, 2);
        chk("load_din", iram_din, 16'hABCD);

        // odd trailing byte is dropped
        pulse_load();
        chk("odd_count_clr", load_count, 0);
        send_byte(8'h55);
        sb.push_back({8'd0, 16'h5566});
        send_byte(8'h66);
        send_byte(8'h77);
        pulse_load();
        tick();
        chk("odd_count", load_count, 1);
        chk("odd_state", state, 0);

        // full memory, back-to-back bytes, auto exit
        pulse_load();
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kk;
            kk = 8'(k);
            rx_data  = kk;
            rx_valid = 1'b1;
            tick();
            rx_data = kk ^ 8'hA5;
            sb.push_back({kk, kk, kk ^ 8'hA5});
            tick();
        end
        rx_data = 8'hEE;
        tick();
        rx_valid = 1'b0;
        chk("full_state", state, 0);
        chk("full_count", load_count, 256);
        chk("full_wa", iram_wa, 255);
        tick();
        tick();
        chk("full_count_hold", load_count, 256);

        // free run with stop at cycle 10
        mon_pc = 16'h0304;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("run_state", state, 2);
        chk("run_cpu_reset", cpu_reset, 0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("run_pulse_c%0d", c), pc_enable, (c % 4 == 0) ? 1 : 0);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("stop_state", state, 0);
        chk("stop_pc_en_c10", pc_enable, 0);
        tick();
        chk("stop_pc_en_c11", pc_enable, 0);
        tick();
        chk("stop_pc_en_c12", pc_enable, 0);

        // single step
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_pulse", pc_enable, 1);
        chk("step_state", state, 0);
        tick();
        chk("step_pulse_end", pc_enable, 0);

        // halt detected at run tick
        mon_pc = 16'h0707;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick(); tick(); tick();
        chk("halt_pre_state", state, 2);
        tick();
        chk("halt_state", state, 3);
        chk("halt_flag", halted, 1);
        chk("halt_no_pulse", pc_enable, 0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("halt_step_ign", state, 3);
        chk("halt_step_pc", pc_enable, 0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("halt_run_ign", state, 3);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("halt_stop_state", state, 0);
        chk("halt_stop_flag", halted, 0);

        // step onto jump-to-self halts
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_halt_state", state, 3);
        chk("step_halt_pc", pc_enable, 0);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;

        // stop beats run in IDLE
        mon_pc = 16'h0304;
        stop_req = 1'b1;
        run_start = 1'b1;
        tick();
        stop_req = 1'b0;
        run_start = 1'b0;
        chk("prio_state", state, 0);
        tick();
        chk("prio_state2", state, 0);

        // async reset mid-run
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_run_state", state, 0);
        chk("arst_run_cpu_reset", cpu_reset, 1);
        chk("arst_run_pc_en", pc_enable, 0);
        #2 reset = 1'b1;
        tick();

        // async reset mid-load, then reload starts on a high byte
        pulse_load();
        sb.push_back({8'd0, 16'h99AA});
        send_byte(8'h99);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 reset = 1'b0;
        #1;
        chk("arst_load_state", state, 0);
        chk("arst_load_count", load_count, 0);
        chk("arst_load_wa", iram_wa, 0);
        chk("arst_load_din", iram_din, 0);
        chk("arst_load_wen", iram_wen, 0);
        chk("arst_load_cpu_reset", cpu_reset, 1);
        #2 reset = 1'b1;
        tick();
        pulse_load();
        sb.push_back({8'd0, 16'hA1B2});
        send_byte(8'hA1);
        send_byte(8'hB2);
        pulse_load();
        chk("reload_count", load_count, 1);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Run-control and program-loader block for the 16-bit microcontroller core. It accepts a byte stream (e.g. from a UART receiver) and writes it as 16-bit words into the core's instruction RAM write port, holding the core in reset meanwhile. It then drives the core's program-counter enable in free-run (rate-divided) or single-step mode. It detects a jump-to-self halt from the core's monitored PC pair.

## Interface
- WIDTH, 16, instruction word width; must be 16 (two bytes per word)
- IRAM_ADDR_BITS, 8, instruction RAM address width
- RUN_DIV, 4, clock cycles per PC advance in RUN; legal range ≥ 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load_start  in  1  one-cycle pulse: start load; in LOAD, terminate load
- run_start  in  1  one-cycle pulse: enter free-run
- step_req  in  1  one-cycle pulse: advance PC once
- stop_req  in  1  one-cycle pulse: leave RUN/HALT to IDLE
- rx_data  in  8  incoming program byte
- rx_valid  in  1  rx_data valid, one cycle per byte
- mon_pc  in  2*IRAM_ADDR_BITS  {PC, PCNext} from the core
- iram_wa  out  IRAM_ADDR_BITS  instruction RAM write address
- iram_wen  out  1  instruction RAM write enable
- iram_din  out  WIDTH  instruction RAM write data
- pc_enable  out  1  PC enable to the core
- cpu_reset  out  1  active-high reset to the core
- state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
- load_count  out  IRAM_ADDR_BITS+1  words written by the last/current load
- halted  out  1  high in HALT

## Operation
- All outputs are registered. Reset values: state=IDLE, cpu_reset=1, pc_enable=0, iram_wen=0, iram_wa=0, iram_din=0, load_count=0, halted=0, byte-phase=high, divider=0.
- cpu_reset is 1 in LOAD and after reset until the first run_start/step_req is accepted. It is 0 otherwise.
- Command priority when pulses coincide: stop_req > load_start > run_start > step_req. Commands that are not legal in the current state are ignored.
- IDLE:
  - load_start → LOAD. This clears load_count and iram_wa and sets byte-phase=high.
  - run_start → RUN and clears the divider.
  - step_req → single step.
- Single step:
  - If PC==PCNext (upper vs lower half of mon_pc), go to HALT with no pulse.
  - Otherwise pulse pc_enable for exactly one cycle and stay in IDLE.
- LOAD:
  - The first rx_valid byte latches as the high byte and the second as the low byte.
  - On the low byte: iram_din={hi,lo}, iram_wen=1 for one cycle at iram_wa=load_count, then load_count+1.
  - After the write cycle, iram_wa holds load_count.
  - Exit to IDLE on load_start, or the cycle after the write that makes load_count=2^IRAM_ADDR_BITS. No address wrap; further bytes are ignored.
  - A pending odd high byte at exit is discarded. stop_req in LOAD also exits to IDLE.
  - run_start/step_req are ignored in LOAD.
- RUN:
  - The divider counts 0..RUN_DIV-1. At count RUN_DIV-1 (tick), check PC==PCNext.
  - If equal: go to HALT, no pulse. Otherwise pc_enable=1 for that one cycle.
  - stop_req → IDLE with no pulse that cycle. load_start → LOAD.
- HALT:
  - halted=1 and pc_enable=0.
  - stop_req → IDLE, load_start → LOAD, run_start/step_req are ignored.
- Asynchronous reset mid-load or mid-run returns everything to reset values immediately. RAM contents are untouched.

## Timing
- Command accepted on the rising edge where its pulse is high. The state output changes the following cycle.
- Step: pc_enable high in the cycle after the step_req edge.
- RUN: first pc_enable occurs RUN_DIV cycles after the run_start edge, then every RUN_DIV cycles. RUN_DIV=1 gives pc_enable high every cycle.
- Load write: iram_wen high in the cycle after the low-byte rx_valid edge. Back-to-back rx_valid every cycle is supported.
- Halt check uses the mon_pc value sampled on the tick edge.

## Test plan
- Load: load_start, bytes 0x12,0x34,0xAB,0xCD, load_start → writes 0x1234@0, 0xABCD@1; load_count=2; cpu_reset=1 throughout LOAD, state returns to IDLE.
- Odd byte: load_start, bytes 0x55,0x66,0x77, load_start → one write 0x5566@0; load_count=1; no write of 0x77.
- Full memory: 512 bytes with IRAM_ADDR_BITS=8 → 256 writes at 0..255; load_count=256; auto-exit to IDLE; byte 513 ignored.
- Run, RUN_DIV=4, mon_pc={0x03,0x04}: run_start → pc_enable pulses at cycles 4,8,12; stop_req at cycle 10 → IDLE, no pulse at 12.
- Halt: RUN with mon_pc={0x07,0x07} at tick → no pulse, state=HALT, halted=1; step_req/run_start ignored; stop_req → IDLE.
- Async reset asserted mid-RUN and mid-LOAD → all outputs at reset values immediately; simultaneous stop_req+run_start in IDLE → stays IDLE.
